// File: rtl/dma_copy_engine.sv
// Memory-to-memory copy sequencer in front of dma_axi: splits a descriptor into
// AXI-legal bursts, reading each burst into a local buffer before writing it back out.
module dma_copy_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_LEN_W = 8,
  parameter int LEN_W     = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [LEN_W-1:0]      len_words,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  ready,
  output logic [AXI_LEN_W-1:0]  dma_len,
  input  logic                  dma_ready
);

  // state   | meaning
  // IDLE    | waiting for start
  // CALC    | size next burst (length cap, 4 KB page on src and dst)
  // RD_WAIT | wait for dma_axi idle before read burst
  // RD      | read beats into buffer
  // WR_PRE  | prefetch buffer word 0, wait for dma_axi idle
  // WR      | write beats out of buffer
  // NEXT    | more words left?
  // FIN     | pulse done
  typedef enum logic [2:0] {IDLE, CALC, RD_WAIT, RD, WR_PRE, WR, NEXT, FIN} state_t;

  localparam int DEPTH = 1 << AXI_LEN_W;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]    src_ptr, dst_ptr;
  logic [LEN_W-1:0]     rem, blen_c;
  logic [AXI_LEN_W-1:0] idx, rd_addr;
  logic [10:0]          src_room, dst_room;
  logic [DATA_W-1:0]    buf_mem [DEPTH];
  logic [DATA_W-1:0]    rd_q;
  logic                 last_beat;
  logic                 unused_addr_lsbs;

  assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};
  assign last_beat        = (idx == dma_len);

  always_comb begin
    src_room = 11'd1024 - {1'b0, src_ptr[11:2]};
    dst_room = 11'd1024 - {1'b0, dst_ptr[11:2]};
    blen_c   = rem;
    if (blen_c > LEN_W'(DEPTH))    blen_c = LEN_W'(DEPTH);
    if (blen_c > LEN_W'(src_room)) blen_c = LEN_W'(src_room);
    if (blen_c > LEN_W'(dst_room)) blen_c = LEN_W'(dst_room);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len_words == '0) ? FIN : CALC;
      CALC:    state_nxt = RD_WAIT;
      RD_WAIT: if (dma_ready) state_nxt = RD;
      RD:      if (ready && last_beat) state_nxt = WR_PRE;
      WR_PRE:  if (dma_ready) state_nxt = WR;
      WR:      if (ready && last_beat) state_nxt = NEXT;
      NEXT:    state_nxt = (rem == '0) ? FIN : CALC;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid   = (state == RD) || (state == WR);
    address = '0;
    wdata   = '0;
    wstrb   = '0;
    if (state == RD) begin
      address = src_ptr;
    end else if (state == WR) begin
      address = dst_ptr;
      wdata   = rd_q;
      wstrb   = '1;
    end
    // Look one word ahead on an accepted write so beats can run back-to-back.
    rd_addr = (state == WR && ready) ? idx + AXI_LEN_W'(1) : idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      src_ptr <= '0;
      dst_ptr <= '0;
      rem     <= '0;
      idx     <= '0;
      dma_len <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= {src_addr[ADDR_W-1:2], 2'b00};
            dst_ptr <= {dst_addr[ADDR_W-1:2], 2'b00};
            rem     <= len_words;
            busy    <= 1'b1;
          end
        end
        CALC: begin
          dma_len <= AXI_LEN_W'(blen_c - LEN_W'(1));
          idx     <= '0;
        end
        RD: begin
          if (ready) begin
            src_ptr <= src_ptr + ADDR_W'(4);
            idx     <= last_beat ? '0 : idx + AXI_LEN_W'(1);
          end
        end
        WR: begin
          if (ready) begin
            dst_ptr <= dst_ptr + ADDR_W'(4);
            idx     <= idx + AXI_LEN_W'(1);
            if (last_beat) rem <= rem - (LEN_W'(dma_len) + LEN_W'(1));
          end
        end
        FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == RD && ready) buf_mem[idx] <= rdata;
    rd_q <= buf_mem[rd_addr];
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: directed descriptor table, random descriptors with
// random stalls, zero-length and reset-mid-write sequences, checked against a burst/word model.
module tb_dma_copy_engine;
  localparam int ADDR_W = 32, DATA_W = 32, AXI_LEN_W = 8, LEN_W = 24;

  logic                 clk = 1'b0;
  logic                 rst, start, ready, dma_ready;
  logic [ADDR_W-1:0]    src_addr, dst_addr, address;
  logic [LEN_W-1:0]     len_words;
  logic                 busy, done, valid;
  logic [DATA_W-1:0]    wdata, rdata;
  logic [DATA_W/8-1:0]  wstrb;
  logic [AXI_LEN_W-1:0] dma_len;

  dma_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_LEN_W(AXI_LEN_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .busy(busy), .done(done), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready), .dma_len(dma_len),
    .dma_ready(dma_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign rdata = mem_val(address);

  int errors = 0, checks = 0;
  int rdy_pct = 100, dmar_pct = 100;
  bit mon_en = 1'b0;

  logic [31:0] exp_rd[$], exp_wr[$], exp_wd[$];
  int          exp_blen[$];
  int          rd_left, reads_seen, writes_seen, bursts_seen, first_dl, last_dl, cur_dl, mb;
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_dmar = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_wstrb;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected access addr %0h expected none at %0t", nm, address, $time);
  endtask

  initial begin
    ready = 1'b1;
    dma_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready     = (int'($urandom_range(99)) < rdy_pct);
      dma_ready = (int'($urandom_range(99)) < dmar_pct);
    end
  end

  // Protocol monitor and scoreboard.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", valid, 1'b1);
        check("hold_addr", address, prev_addr);
        check("hold_wdata", wdata, prev_wdata);
        check("hold_wstrb", wstrb, prev_wstrb);
      end
      if (valid && !prev_valid) check("burst_gated_by_dma_ready", prev_dmar, 1'b1);
      if (valid && ready) begin
        if (wstrb == 4'h0) begin
          if (rd_left == 0) begin
            if (exp_blen.size() == 0) fail("extra_burst");
            else begin
              mb = exp_blen.pop_front();
              rd_left = mb;
              cur_dl = mb - 1;
              bursts_seen++;
              if (bursts_seen == 1) first_dl = int'(dma_len);
              last_dl = int'(dma_len);
            end
          end
          if (rd_left > 0) rd_left--;
          check("rd_dma_len", dma_len, cur_dl);
          if (exp_rd.size() == 0) fail("extra_read");
          else check("rd_addr", address, exp_rd.pop_front());
          reads_seen++;
        end else if (wstrb == 4'hF) begin
          check("wr_dma_len", dma_len, cur_dl);
          if (exp_wr.size() == 0) fail("extra_write");
          else begin
            check("wr_addr", address, exp_wr.pop_front());
            check("wr_data", wdata, exp_wd.pop_front());
          end
          writes_seen++;
        end else check("wstrb_legal", wstrb, 4'h0);
      end
      prev_valid = valid;
      prev_ready = ready;
      prev_addr  = address;
      prev_wdata = wdata;
      prev_wstrb = wstrb;
    end else prev_valid = 1'b0;
    prev_dmar = dma_ready;
  end

  task automatic run_copy(input logic [31:0] s_in, input logic [31:0] d_in, input int n,
                          input int rp, input int dp, input bit xs,
                          input int eb_in, input int ef_in, input int el_in);
    logic [31:0] s, d;
    int remw, b, sr, dr, cyc, budget, eb, ef, el;
    exp_rd.delete(); exp_wr.delete(); exp_wd.delete(); exp_blen.delete();
    rd_left = 0; reads_seen = 0; writes_seen = 0; bursts_seen = 0;
    first_dl = -1; last_dl = -1; cur_dl = 0;
    s = s_in & ~32'h3;
    d = d_in & ~32'h3;
    remw = n;
    while (remw > 0) begin
      b  = (remw > 256) ? 256 : remw;
      sr = 1024 - int'((s >> 2) & 32'h3FF);
      dr = 1024 - int'((d >> 2) & 32'h3FF);
      if (sr < b) b = sr;
      if (dr < b) b = dr;
      exp_blen.push_back(b);
      for (int k = 0; k < b; k++) begin
        exp_rd.push_back(s);
        exp_wr.push_back(d);
        exp_wd.push_back(mem_val(s));
        s = s + 32'd4;
        d = d + 32'd4;
      end
      remw -= b;
    end
    eb = eb_in; ef = ef_in; el = el_in;
    if (eb < 0) begin
      eb = exp_blen.size();
      ef = exp_blen[0] - 1;
      el = exp_blen[exp_blen.size()-1] - 1;
    end
    rdy_pct = rp;
    dmar_pct = dp;
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; src_addr = s_in; dst_addr = d_in; len_words = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    budget = n * 30 + 200;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (xs && cyc == 20) begin
        start = 1'b1; src_addr = 32'h9000; dst_addr = 32'hA000; len_words = 3;
      end else start = 1'b0;
    end while (done !== 1'b1 && cyc < budget);
    start = 1'b0;
    check("done_seen", done, 1'b1);
    check("busy_low_at_done", busy, 1'b0);
    check("read_count", reads_seen, n);
    check("write_count", writes_seen, n);
    check("burst_count", bursts_seen, eb);
    check("first_dma_len", first_dl, ef);
    check("last_dma_len", last_dl, el);
    check("reads_left", exp_rd.size(), 0);
    check("writes_left", exp_wr.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    repeat (3) @(negedge clk);
    check("stays_idle", busy, 1'b0);
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          rp;
    int          dp;
    bit          xs;
    int          eb;
    int          ef;
    int          el;
  } vec_t;

  vec_t vecs[6];
  int   cyc;
  bit   seen;

  initial begin
    vecs[0] = '{32'h0000_1000, 32'h0000_2000,   8, 100, 100, 1'b0, 1,   7,  7};
    vecs[1] = '{32'h0000_0000, 32'h0001_0000, 600, 100, 100, 1'b0, 3, 255, 87};
    vecs[2] = '{32'h0000_1FF0, 32'h0000_3000,  10, 100, 100, 1'b0, 2,   3,  5};
    vecs[3] = '{32'h0000_1000, 32'h0000_3FF8,   4, 100, 100, 1'b0, 2,   1,  1};
    vecs[4] = '{32'h0000_0FE0, 32'h0000_5100,  40,  60,  50, 1'b1, 2,   7, 31};
    vecs[5] = '{32'hFFFF_FFF0, 32'h0000_0100,   6,  70, 100, 1'b0, 2,   3,  1};

    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_address", address, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_wstrb", wstrb, 4'h0);
    check("rst_dma_len", dma_len, 8'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_copy(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].rp, vecs[i].dp, vecs[i].xs,
               vecs[i].eb, vecs[i].ef, vecs[i].el);

    // Zero length: FIN straight from IDLE, done one cycle later, no access.
    rdy_pct = 100; dmar_pct = 100;
    @(posedge clk); #1;
    start = 1'b1; src_addr = 32'h1234; dst_addr = 32'h5678; len_words = '0;
    @(posedge clk); #1;
    start = 1'b0;
    check("zl_done_in_fin", done, 1'b0);
    check("zl_valid_in_fin", valid, 1'b0);
    @(posedge clk); #1;
    check("zl_done", done, 1'b1);
    check("zl_busy", busy, 1'b0);
    check("zl_valid", valid, 1'b0);
    @(posedge clk); #1;
    check("zl_done_drop", done, 1'b0);
    check("zl_busy_after", busy, 1'b0);

    // Reset in the middle of a write burst.
    mon_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; src_addr = 32'h4000; dst_addr = 32'h8000; len_words = 64;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(valid === 1'b1 && wstrb === 4'hF) && cyc < 500);
    check("reach_write_phase", wstrb, 4'hF);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || valid === 1'b1) seen = 1'b1;
    end
    check("no_done_after_rst", seen, 1'b0);
    run_copy(32'h0000_0100, 32'h0000_0700, 4, 100, 100, 1'b0, 1, 3, 3);

    for (int i = 0; i < 4; i++)
      run_copy($urandom, $urandom, int'($urandom_range(300, 1)), int'($urandom_range(100, 30)),
               int'($urandom_range(100, 30)), 1'b0, -1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
